// File: rtl/shift_reg_checker_pkg.sv
// Shared types and constants for the universal shift-register checker.
//   state_e    : checker sequencer states
//   MODE_*     : 74194-style mode-select encodings
//   vec_width  : stimulus vector width for a given register width
package shift_reg_checker_pkg;

  typedef enum logic [2:0] {
    StHalted,
    StInit,
    StDriveLo,
    StCheckLo,
    StDriveHi,
    StCheckHi,
    StNext,
    StDone
  } state_e;

  localparam logic [1:0] MODE_HOLD = 2'b00;
  localparam logic [1:0] MODE_SHR  = 2'b01;
  localparam logic [1:0] MODE_SHL  = 2'b10;
  localparam logic [1:0] MODE_LOAD = 2'b11;

  // d, sr, sl, two mode bits and the clear bit.
  function automatic int unsigned vec_width(input int unsigned width);
    return width + 5;
  endfunction

endpackage

// File: rtl/shift_reg_checker_if.sv
// Socket bus between the checker and the shift register under test.
//   master : checker side, drives the DUT pins and observes dut_q
//   slave  : socket side, receives the drives and returns dut_q
interface shift_reg_checker_if #(
  parameter int unsigned WIDTH = 4
) ();

  logic             dut_clk;
  logic             dut_clr_n;
  logic [1:0]       dut_s;
  logic             dut_sr;
  logic             dut_sl;
  logic [WIDTH-1:0] dut_d;
  logic [WIDTH-1:0] dut_q;

  modport master (
    output dut_clk, dut_clr_n, dut_s, dut_sr, dut_sl, dut_d,
    input  dut_q
  );

  modport slave (
    input  dut_clk, dut_clr_n, dut_s, dut_sr, dut_sl, dut_d,
    output dut_q
  );

endinterface

// File: rtl/shreg_model.sv
// Golden model of a 74194-style universal shift register.
//   Clk, Reset : system clock, async active-low reset
//   clr_n      : clear, forces q to zero at once and clears the state
//   en         : one-cycle strobe standing in for the DUT clock rising edge
//   s, sr, sl  : mode select, serial-right and serial-left inputs
//   d          : parallel load data
//   q          : model register contents as the DUT should present them
module shreg_model
  import shift_reg_checker_pkg::*;
#(
  parameter int unsigned WIDTH = 4
) (
  input  logic             Clk,
  input  logic             Reset,
  input  logic             clr_n,
  input  logic             en,
  input  logic [1:0]       s,
  input  logic             sr,
  input  logic             sl,
  input  logic [WIDTH-1:0] d,
  output logic [WIDTH-1:0] q
);

  logic [WIDTH-1:0] q_q, q_d;

  always_comb begin
    q_d = q_q;
    case (s)
      MODE_SHR:  q_d = {q_q[WIDTH-2:0], sr};
      MODE_SHL:  q_d = {sl, q_q[WIDTH-1:1]};
      MODE_LOAD: q_d = d;
      default:   q_d = q_q;
    endcase
  end

  always_ff @(posedge Clk or negedge Reset) begin
    if (!Reset) begin
      q_q <= '0;
    end else if (!clr_n) begin
      q_q <= '0;
    end else if (en) begin
      q_q <= q_d;
    end
  end

  // Clear acts asynchronously on the chip, so mask the output immediately.
  assign q = clr_n ? q_q : '0;

endmodule

// File: rtl/shift_reg_checker.sv
// Exhaustive checker for a socketed universal shift register.
//   Clk, Reset   : system clock, async active-low reset
//   Run          : start request, honoured only while halted
//   DISP_RSLT    : display acknowledge, releases Done
//   sock         : DUT socket bus (drives out, dut_q in)
//   Done         : sweep finished, result valid
//   RSLT         : 1 = every sample matched
//   err_count    : saturating count of mismatching samples
//   fail_vec/hi/q: vector, phase and dut_q of the first mismatch
//   model_q      : golden model state for display
module shift_reg_checker
  import shift_reg_checker_pkg::*;
#(
  parameter int unsigned WIDTH      = 4,
  parameter int unsigned SETTLE_CYC = 2,
  parameter int unsigned PASSES     = 1,
  parameter int unsigned ERR_W      = 8
) (
  input  logic                  Clk,
  input  logic                  Reset,
  input  logic                  Run,
  input  logic                  DISP_RSLT,
  shift_reg_checker_if.master   sock,
  output logic                  Done,
  output logic                  RSLT,
  output logic [ERR_W-1:0]      err_count,
  output logic [WIDTH+4:0]      fail_vec,
  output logic                  fail_hi,
  output logic [WIDTH-1:0]      fail_q,
  output logic [WIDTH-1:0]      model_q
);

  localparam int unsigned VecW  = vec_width(WIDTH);
  localparam int unsigned PassW = (PASSES > 1) ? $clog2(PASSES) : 1;

  state_e           state_q, state_d;
  logic [3:0]       cnt_q, cnt_d;
  logic [VecW-1:0]  vec_q, vec_d;
  logic [PassW-1:0] pass_q, pass_d;

  // Sequencer
  always_comb begin
    state_d = state_q;
    cnt_d   = cnt_q + 4'd1;
    vec_d   = vec_q;
    pass_d  = pass_q;
    case (state_q)
      StHalted: begin
        cnt_d = '0;
        if (Run) state_d = StInit;
      end
      StInit: begin
        vec_d  = '0;
        pass_d = '0;
        if (cnt_q == 4'(SETTLE_CYC)) begin
          state_d = StDriveLo;
          cnt_d   = '0;
        end
      end
      StDriveLo: begin
        if (cnt_q == 4'(SETTLE_CYC - 1)) state_d = StCheckLo;
      end
      StCheckLo: begin
        state_d = StDriveHi;
        cnt_d   = '0;
      end
      StDriveHi: begin
        if (cnt_q == 4'(SETTLE_CYC - 1)) state_d = StCheckHi;
      end
      StCheckHi: state_d = StNext;
      StNext: begin
        cnt_d = '0;
        if ((&vec_q) && (pass_q == PassW'(PASSES - 1))) begin
          state_d = StDone;
        end else begin
          vec_d   = vec_q + VecW'(1);
          if (&vec_q) pass_d = pass_q + PassW'(1);
          state_d = StDriveLo;
        end
      end
      StDone: begin
        cnt_d = '0;
        if (DISP_RSLT) state_d = StHalted;
      end
      default: state_d = StHalted;
    endcase
  end

  always_ff @(posedge Clk or negedge Reset) begin
    if (!Reset) begin
      state_q <= StHalted;
      cnt_q   <= '0;
      vec_q   <= '0;
      pass_q  <= '0;
    end else begin
      state_q <= state_d;
      cnt_q   <= cnt_d;
      vec_q   <= vec_d;
      pass_q  <= pass_d;
    end
  end

  // DUT pin drives, registered from the current state so the pins are glitch-free
  // and each level is held exactly SETTLE_CYC cycles before its compare edge.
  logic             clk_d, clk_q, clr_n_d, clr_n_q, sr_d, sr_q, sl_d, sl_q;
  logic [1:0]       s_d, s_q;
  logic [WIDTH-1:0] d_d, d_q;

  always_comb begin
    clk_d   = 1'b0;
    clr_n_d = 1'b0;
    s_d     = MODE_HOLD;
    sr_d    = 1'b0;
    sl_d    = 1'b0;
    d_d     = '0;
    case (state_q)
      StDriveLo, StCheckLo, StDriveHi, StCheckHi, StNext: begin
        clk_d   = (state_q == StDriveHi) || (state_q == StCheckHi);
        clr_n_d = ~vec_q[WIDTH+4];
        s_d     = vec_q[WIDTH+3:WIDTH+2];
        sl_d    = vec_q[WIDTH+1];
        sr_d    = vec_q[WIDTH];
        d_d     = vec_q[WIDTH-1:0];
      end
      default: ;
    endcase
  end

  always_ff @(posedge Clk or negedge Reset) begin
    if (!Reset) begin
      clk_q   <= 1'b0;
      clr_n_q <= 1'b0;
      s_q     <= '0;
      sr_q    <= 1'b0;
      sl_q    <= 1'b0;
      d_q     <= '0;
    end else begin
      clk_q   <= clk_d;
      clr_n_q <= clr_n_d;
      s_q     <= s_d;
      sr_q    <= sr_d;
      sl_q    <= sl_d;
      d_q     <= d_d;
    end
  end

  assign sock.dut_clk   = clk_q;
  assign sock.dut_clr_n = clr_n_q;
  assign sock.dut_s     = s_q;
  assign sock.dut_sr    = sr_q;
  assign sock.dut_sl    = sl_q;
  assign sock.dut_d     = d_q;

  // The model steps on the same edge that raises dut_clk, using the same pin levels.
  logic [WIDTH-1:0] mdl_q;

  shreg_model #(
    .WIDTH (WIDTH)
  ) u_model (
    .Clk   (Clk),
    .Reset (Reset),
    .clr_n (clr_n_q),
    .en    ((state_q == StDriveHi) && (cnt_q == '0)),
    .s     (s_q),
    .sr    (sr_q),
    .sl    (sl_q),
    .d     (d_q),
    .q     (mdl_q)
  );

  assign model_q = mdl_q;

  // Result capture
  logic             mismatch;
  logic             rslt_q, fail_hi_q, done_q;
  logic [ERR_W-1:0] err_q;
  logic [VecW-1:0]  fail_vec_q;
  logic [WIDTH-1:0] fail_q_q;

  assign mismatch = ((state_q == StCheckLo) || (state_q == StCheckHi)) &&
                    (sock.dut_q != mdl_q);

  always_ff @(posedge Clk or negedge Reset) begin
    if (!Reset) begin
      rslt_q     <= 1'b0;
      err_q      <= '0;
      fail_vec_q <= '0;
      fail_hi_q  <= 1'b0;
      fail_q_q   <= '0;
      done_q     <= 1'b0;
    end else begin
      done_q <= (state_q == StDone) && !DISP_RSLT;
      if (state_q == StInit) begin
        rslt_q     <= 1'b1;
        err_q      <= '0;
        fail_vec_q <= '0;
        fail_hi_q  <= 1'b0;
        fail_q_q   <= '0;
      end else if (mismatch) begin
        rslt_q <= 1'b0;
        if (!(&err_q)) err_q <= err_q + ERR_W'(1);
        // err_q only grows, so zero marks the first mismatch of the run.
        if (err_q == '0) begin
          fail_vec_q <= vec_q;
          fail_hi_q  <= (state_q == StCheckHi);
          fail_q_q   <= sock.dut_q;
        end
      end
    end
  end

  assign Done      = done_q;
  assign RSLT      = rslt_q;
  assign err_count = err_q;
  assign fail_vec  = fail_vec_q;
  assign fail_hi   = fail_hi_q;
  assign fail_q    = fail_q_q;

endmodule

// File: doc/shift_reg_checker.md
Name: shift_reg_checker

Overview:
- Parametrised successor to the team's fixed-function shift-register chip checkers.
- Exhaustively drives a socketed universal shift register (74194-style: async clear, 2-bit mode select, serial right/left inputs, parallel load, WIDTH bits) through every control/data vector.
- Compares DUT outputs against an internal golden model at two sample points per vector and reports pass/fail, error count and first-failure capture.
- Sits between the board pin mux and the result-display logic, using the existing Run / Done / DISP_RSLT handshake.

Parameters:
- WIDTH, 4: DUT register width (supported 2..8).
- SETTLE_CYC, 2: Clk cycles that drive levels are held before each sample (1..15).
- PASSES, 1: full sweeps per run; model and DUT state carry over between passes.
- ERR_W, 8: error counter width (saturating).

Ports:
- Clk  in  1  system clock.
- Reset  in  1  asynchronous, active-low reset.
- Run  in  1  start request, sampled in HALTED only.
- DISP_RSLT  in  1  display acknowledge; releases DONE.
- dut_q  in  WIDTH  DUT parallel outputs.
- dut_clk  out  1  DUT clock.
- dut_clr_n  out  1  DUT clear, active-low.
- dut_s  out  2  DUT mode select.
- dut_sr  out  1  serial-right input.
- dut_sl  out  1  serial-left input.
- dut_d  out  WIDTH  parallel data.
- Done  out  1  high in DONE.
- RSLT  out  1  1 = pass.
- err_count  out  ERR_W  mismatching samples, saturating.
- fail_vec  out  WIDTH+5  vector index of the first mismatch.
- fail_hi  out  1  first mismatch was at the high-phase sample.
- fail_q  out  WIDTH  dut_q observed at the first mismatch.
- model_q  out  WIDTH  golden model state, for display.

Behaviour:
- Reset low: state HALTED; all outputs 0, including RSLT, err_count and fail_*. Asynchronous, so it aborts any run.
- Vector layout, VEC_W = WIDTH+5, counted 0 .. 2^VEC_W-1:
  - dut_d = vec[WIDTH-1:0]
  - dut_sr = vec[WIDTH]
  - dut_sl = vec[WIDTH+1]
  - dut_s = vec[WIDTH+3:WIDTH+2]
  - dut_clr_n = ~vec[WIDTH+4]
- Model behaviour:
  - Clear low: Q = 0 immediately (combinationally in the model).
  - Otherwise, on dut_clk rise:
    - s=00 hold.
    - s=01 shift right: Q0 <= SR, Qi <= Qi-1.
    - s=10 shift left: Q(W-1) <= SL, Qi <= Qi+1.
    - s=11 load D.
- States:
  - HALTED: drives 0; Run=1 -> INIT.
  - INIT: SETTLE_CYC+1 cycles with dut_clr_n=0.
    - Model, vec and pass counter cleared.
    - RSLT set to 1; err_count and fail_* cleared.
    - -> DRIVE_LO.
  - DRIVE_LO: SETTLE_CYC cycles, vector levels driven, dut_clk=0 -> CHECK_LO.
  - CHECK_LO: 1 cycle, compare dut_q with model -> DRIVE_HI.
  - DRIVE_HI: SETTLE_CYC cycles, dut_clk=1; model updates on the first cycle -> CHECK_HI.
  - CHECK_HI: 1 cycle, compare -> NEXT.
  - NEXT: 1 cycle, dut_clk=0.
    - If vec wraps and the pass counter reaches PASSES-1 -> DONE.
    - Otherwise vec++ (the pass counter increments on wrap) -> DRIVE_LO.
  - DONE: Done=1, DUT drives 0; DISP_RSLT=1 -> HALTED.
- On any mismatch:
  - RSLT <= 0.
  - err_count increments, saturating at all-ones.
  - On the first mismatch only: fail_vec, fail_hi and fail_q are latched.
- RSLT, err_count and fail_* hold through DONE and HALTED until the next INIT.
- Run while not in HALTED is ignored. DISP_RSLT outside DONE is ignored.
- Latency: Done first asserts (SETTLE_CYC+1) + PASSES·2^VEC_W·(2·SETTLE_CYC+3) + 1 cycles after the edge sampling Run in HALTED.

Decomposition:
- Package shift_reg_checker_pkg holds:
  - state enum
  - mode constants MODE_HOLD, MODE_SHR, MODE_SHL, MODE_LOAD
  - helper function vec_width(WIDTH)
- Sub-module shreg_model (parametrised WIDTH): golden register with clr_n, s, sr, sl, d and a clock-enable strobe. Keeps the checker FSM separate from chip semantics.

Test Plan:
- WIDTH=4, SETTLE_CYC=2, PASSES=1, behavioural-correct DUT; Run pulse -> Done after 3+512·7+1 = 3588 cycles, RSLT=1, err_count=0. DISP_RSLT -> HALTED next cycle; RSLT stays 1.
- Same configuration, DUT Q2 stuck-at-0 -> RSLT=0, fail_vec=0x052, fail_hi=1, fail_q=4'b0011, err_count>0.
- DUT outputs inverted, ERR_W=4 -> err_count saturates at 15, fail_vec=0x000, fail_hi=0, fail_q=4'b1111.
- Reset asserted mid-DRIVE_HI -> same edge: all DUT drives 0, RSLT=0, err_count=0. A later Run restarts from vector 0.
- Run held high through the sweep and DONE -> no restart while busy. After DISP_RSLT, HALTED re-samples Run and re-enters INIT one cycle later.
- WIDTH=8, SETTLE_CYC=1, PASSES=2, correct DUT -> 2·8192 vectors, Done after 2+16384·5+1 cycles, RSLT=1; model_q continues across the pass boundary without clearing.
